// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in per gate window.
// Optional glitch filter compiled in with `define FREQ_METER_GLITCH_FILTER_EN.
module freq_meter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int GATE_MS  = 1000,
  parameter int CNT_W    = 26,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             valid,
  output logic             overflow
);

  localparam int GATE_CYCLES = (CLK_FREQ / 1000) * GATE_MS;
  localparam int GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_level;
  logic              r_prev;
  logic              w_edge;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_sat_next;
  logic              w_terminal;

  // two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILT_LEN) + 1;
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);

  logic              r_filt;
  logic [FCNT_W-1:0] r_filt_cnt;

  // level follows the synced input only after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt     <= 1'b0;
      r_filt_cnt <= {FCNT_W{1'b0}};
    end else if (r_sync2 != r_filt) begin
      if (r_filt_cnt == FILT_LAST) begin
        r_filt     <= r_sync2;
        r_filt_cnt <= {FCNT_W{1'b0}};
      end else begin
        r_filt_cnt <= r_filt_cnt + FCNT_W'(1);
      end
    end else begin
      r_filt_cnt <= {FCNT_W{1'b0}};
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // previous level tracks every cycle, so entering RUN never sees a stale edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_edge     = w_level & ~r_prev;
  assign w_terminal = (r_state == RUN) && (r_gate_cnt == GATE_LAST);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // saturating edge count including this cycle's edge
  always_comb begin
    w_cnt_next = r_edge_cnt;
    w_sat_next = r_sat;
    if (w_edge) begin
      if (r_edge_cnt == CNT_MAX) begin
        w_sat_next = 1'b1;
      end else begin
        w_cnt_next = r_edge_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_next = r_edge_cnt;
    end
  end

  // gate window counting and result publication
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gate_cnt <= {GATE_W{1'b0}};
      r_edge_cnt <= {CNT_W{1'b0}};
      r_sat      <= 1'b0;
      freq_hz    <= {CNT_W{1'b0}};
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_terminal) begin
        r_gate_cnt <= {GATE_W{1'b0}};
        r_edge_cnt <= {CNT_W{1'b0}};
        r_sat      <= 1'b0;
        freq_hz    <= w_cnt_next;
        overflow   <= w_sat_next;
        valid      <= 1'b1;
      end else begin
        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        r_edge_cnt <= w_cnt_next;
        r_sat      <= w_sat_next;
        valid      <= 1'b0;
      end
    end else begin
      r_gate_cnt <= {GATE_W{1'b0}};
      r_edge_cnt <= {CNT_W{1'b0}};
      r_sat      <= 1'b0;
      valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: constant-expectation window table, corner
// sequences, and randomized stimulus against an edge-counting reference model.
module tb_freq_meter;

  localparam int CLK_FREQ = 100_000;
  localparam int GATE_MS  = 2;
  localparam int CNT_W    = 5;
  localparam int FILT_LEN = 4;
  localparam int G        = (CLK_FREQ / 1000) * GATE_MS;
  localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic [CNT_W-1:0] freq_hz;
  logic valid;
  logic overflow;

  freq_meter #(
    .CLK_FREQ(CLK_FREQ), .GATE_MS(GATE_MS), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_hz(freq_hz), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_sync1, m_s, m_f, m_lprev, m_run, m_valid, m_ovf;
  int m_idx, m_cnt, m_freq;
  bit m_sq[$];

  typedef struct {
    int period;
    int high;
    int exp_nf;
    int exp_f;
    bit ovf_nf;
    bit ovf_f;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function void model_reset();
    m_sync1 = 0; m_s = 0; m_f = 0; m_lprev = 0; m_run = 0; m_valid = 0; m_ovf = 0;
    m_idx = 0; m_cnt = 0; m_freq = 0;
    m_sq.delete();
  endfunction

  function void model_edge();
    bit lcur, e_v, all_diff;
    if (!rst) begin
      model_reset();
      return;
    end
    lcur = FILT_ON ? m_f : m_s;
    e_v = lcur && !m_lprev;
    m_valid = 0;
    if (m_run) begin
      m_cnt += int'(e_v);
      if (m_idx == G - 1) begin
        m_freq = (m_cnt > MAXC) ? MAXC : m_cnt;
        m_ovf = (m_cnt > MAXC);
        m_valid = 1;
        m_cnt = 0;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      m_cnt = 0;
      m_idx = 0;
    end
    m_run = en;
    // filter: level adopts the synced value once the last FILT_LEN samples all disagree with it
    m_sq.push_back(m_s);
    if (m_sq.size() > FILT_LEN) void'(m_sq.pop_front());
    all_diff = (m_sq.size() == FILT_LEN);
    foreach (m_sq[i]) if (m_sq[i] == m_f) all_diff = 0;
    if (all_diff) m_f = m_s;
    m_lprev = lcur;
    m_s = m_sync1;
    m_sync1 = sig_in;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", int'(valid), int'(m_valid));
    chk("freq_hz", int'(freq_hz), m_freq);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_freq", int'(freq_hz), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // after the en-sampling edge, counts edges to the next valid; drives a periodic sig
  task automatic wait_valid(input int p, input int h, inout int ph, output int n);
    n = 0;
    while (n <= 2 * G + 10) begin
      sig_in = ((ph % p) < h);
      ph++;
      tick();
      n++;
      if (valid) break;
    end
  endtask

  int nval, ph, n, hold, exp_fr, exp_ov;

  initial begin
    tbl[0] = '{10, 5, 20, 20, 1'b0, 1'b0};
    tbl[1] = '{8, 4, 25, 25, 1'b0, 1'b0};
    tbl[2] = '{4, 2, MAXC, 0, 1'b1, 1'b0};
    tbl[3] = '{50, 25, 4, 4, 1'b0, 1'b0};
    tbl[4] = '{100, 2, 2, 0, 1'b0, 1'b0};
    tbl[5] = '{100, 6, 2, 2, 1'b0, 1'b0};

    model_reset();
    do_reset();
    repeat (3) tick();

    // sig held high across en rising: first result must be zero
    sig_in = 1'b1;
    repeat (10) tick();
    en = 1'b1;
    tick();
    ph = 0;
    wait_valid(1, 1, ph, n);
    chk("held_high_latency", n, G);
    chk("held_high_freq", int'(freq_hz), 0);
    chk("held_high_ovf", int'(overflow), 0);

    // steady-state windows: check the second completed window of each pattern
    foreach (tbl[k]) begin
      en = 1'b0;
      sig_in = 1'b0;
      repeat (4) tick();
      en = 1'b1;
      nval = 0;
      exp_fr = FILT_ON ? tbl[k].exp_f : tbl[k].exp_nf;
      exp_ov = FILT_ON ? int'(tbl[k].ovf_f) : int'(tbl[k].ovf_nf);
      for (int c = 0; c < 3 * G + 10 && nval < 2; c++) begin
        sig_in = ((c % tbl[k].period) < tbl[k].high);
        tick();
        if (valid) begin
          nval++;
          if (nval == 2) begin
            chk($sformatf("tbl%0d_freq", k), int'(freq_hz), exp_fr);
            chk($sformatf("tbl%0d_ovf", k), int'(overflow), exp_ov);
          end
        end
      end
      if (nval < 2) chk($sformatf("tbl%0d_timeout", k), nval, 2);
    end

    // abort mid-window: no valid, result held, restart timing from re-raise
    en = 1'b0;
    sig_in = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    tick();
    ph = 0;
    wait_valid(10, 5, ph, n);
    wait_valid(10, 5, ph, n);
    chk("pre_abort_freq", int'(freq_hz), 20);
    for (int c = 0; c < 80; c++) begin
      sig_in = ((ph % 10) < 5);
      ph++;
      tick();
    end
    en = 1'b0;
    nval = 0;
    ph = 0;
    for (int c = 0; c < 30; c++) begin
      sig_in = ((ph % 8) < 4);
      ph++;
      tick();
      if (valid) nval++;
    end
    chk("abort_no_valid", nval, 0);
    chk("abort_freq_hold", int'(freq_hz), 20);
    en = 1'b1;
    sig_in = ((ph % 8) < 4);
    ph++;
    tick();
    wait_valid(8, 4, ph, n);
    chk("abort_restart_latency", n, G);
    chk("abort_restart_freq", int'(freq_hz), 25);

    // reset mid-window: outputs clear at once, restart timing as from power-up
    for (int c = 0; c < 120; c++) begin
      sig_in = ((ph % 8) < 4);
      ph++;
      tick();
    end
    do_reset();
    chk("post_rst_freq", int'(freq_hz), 0);
    sig_in = ((ph % 8) < 4);
    ph++;
    tick();
    wait_valid(8, 4, ph, n);
    chk("rst_restart_latency", n, G);

    // randomized stimulus against the model
    hold = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) do_reset();
      hold--;
      if (hold <= 0) begin
        sig_in = ~sig_in;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 9));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter GATE_MS, default 1000, measurement window length in ms.
REQ-003 SHALL have parameter CNT_W, default 26, width of count result.
REQ-004 SHALL have parameter FILT_LEN, default 4, glitch-filter stability length in clk cycles (min 2).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  measurement enable, synchronous to clk.
REQ-008 sig_in  input  1  asynchronous signal under measurement, e.g. output of a divided clock.
REQ-009 freq_hz  output  CNT_W  rising edges counted in last completed window (Hz when GATE_MS=1000).
REQ-010 valid  output  1  one-cycle pulse when freq_hz updates.
REQ-011 overflow  output  1  last completed window saturated.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Rising edge SHALL be detected as synced level = 1 while previous-level register = 0.
REQ-014 GATE_CYCLES SHALL equal (CLK_FREQ/1000)*GATE_MS; gate counter runs 0..GATE_CYCLES-1, then wraps to 0.
REQ-015 FSM states: IDLE, RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; no other transitions.
REQ-016 In IDLE: gate and edge counters held at 0, previous-level register loads current level each cycle (no false edge on entering RUN), freq_hz and overflow hold, valid=0.
REQ-017 First RUN cycle SHALL be gate count 0; first valid SHALL occur GATE_CYCLES cycles after IDLE->RUN.
REQ-018 In RUN each detected edge SHALL increment edge counter, including an edge in the terminal (GATE_CYCLES-1) cycle.
REQ-019 At terminal cycle: freq_hz <= edge count including that cycle's edge; overflow <= saturation flag; valid=1 next cycle for exactly one cycle; edge counter and saturation flag cleared; next window starts immediately with no dead cycle.
REQ-020 Edge counter SHALL saturate at 2^CNT_W-1 and set saturation flag; no wrap-around.
REQ-021 en falling mid-window SHALL discard partial count; no valid issued; freq_hz unchanged.
REQ-022 valid and freq_hz SHALL be registered outputs.

Reset
REQ-023 rst=0 SHALL asynchronously force: FSM=IDLE, synchronizer/filter/previous-level registers=0, all counters=0, freq_hz=0, valid=0, overflow=0.
REQ-024 Reset asserted mid-window SHALL abort window; after release block behaves as from power-up (REQ-017 timing from first RUN cycle).

Configuration
REQ-025 Macro FREQ_METER_GLITCH_FILTER_EN SHALL compile in a glitch filter between synchronizer and edge detector.
REQ-026 With macro defined: filtered level SHALL change only after synced level differs from it for FILT_LEN consecutive cycles; shorter pulses rejected; edge latency increases by FILT_LEN cycles.
REQ-027 Without macro: edge detector SHALL use synced level directly; no filter logic present.

Verification
REQ-028 rst=0 at any time -> freq_hz=0, valid=0, overflow=0 within same cycle; held until rst=1.
REQ-029 GATE_MS=1, en=1, sig_in 1 MHz square (50-cycle period) -> freq_hz=1000 (+/-1), valid pulse every 50000 cycles, overflow=0.
REQ-030 sig_in held 1 before and during en 0->1, GATE_MS=1 -> first result freq_hz=0.
REQ-031 CNT_W=8, GATE_MS=1, sig_in 12.5 MHz (4-cycle period) -> freq_hz=255, overflow=1; then sig_in 100 kHz -> next window freq_hz=100, overflow=0.
REQ-032 en dropped at gate count 20000 then re-raised -> no valid for aborted window, freq_hz holds prior value, next valid exactly GATE_CYCLES after re-raise; rst pulse at gate count 30000 -> freq_hz=0, same restart timing.
REQ-033 2-cycle-wide high pulses every 100 cycles, GATE_MS=1 -> with FREQ_METER_GLITCH_FILTER_EN freq_hz=0; without freq_hz=500.
